psum_gb_rr_merger: RTL and testbench
====================================

Name: psum_gb_rr_merger

Overview:
- Parametrised successor to the fixed three-channel PSUM val/rdy return path from PE blocks to the global buffer (GB).
- Accepts NUM_CH independent PSUM val/rdy streams, buffers each in its own FIFO, and merges them onto one GB write port.
- Each output word is tagged with its source channel.
- Arbitration is selectable: round-robin or fixed priority. Channels can be individually masked.

Parameters:
- NUM_CH, 3, number of PSUM input channels (>=2)
- DATA_W, 368, PSUM row width (PSUM_WIDTH*LENROW)
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)
- CH_W, 2, width of channel tag; must be >= ceil(log2(NUM_CH)), minimum 1

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_val  input  NUM_CH  per-channel PSUM valid from PE side
- in_rdy  output  NUM_CH  per-channel ready to PE side
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- mode_fixed  input  1  1 = fixed priority (lowest index wins), 0 = round-robin
- ch_en  input  NUM_CH  arbitration enable mask; a masked channel still accepts into its FIFO but is never granted
- out_val  output  1  merged PSUM valid to GB
- out_rdy  input  1  GB ready
- out_data  output  DATA_W  merged PSUM row
- out_ch  output  CH_W  source channel of out_data
- busy  output  1  any FIFO non-empty or out_val high

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all FIFOs empty; out_val=0, out_data=0, out_ch=0, busy=0
  - round-robin last-grant pointer = NUM_CH-1, so channel 0 has top priority
  - after release, in_rdy is all ones.
- Input side:
  - in_rdy[i] = FIFO i count < FIFO_DEPTH, using the count before any same-cycle pop. No bypass.
  - Push occurs when in_val[i] & in_rdy[i].
  - in_rdy does not depend on in_val.
- Output register:
  - Single-stage, holding out_val/out_data/out_ch.
  - Loads when (!out_val | out_rdy) and at least one eligible FIFO exists.
  - Eligible means non-empty & ch_en[i].
  - If it can load but no channel is eligible, it clears out_val on the handshake.
  - While out_val=1 & out_rdy=0, out_data and out_ch hold stable.
- Arbiter:
  - Combinational grant among eligible channels.
  - RR mode: search starts at last_grant+1 mod NUM_CH. last_grant updates only on an actual load.
  - Fixed mode: lowest eligible index wins. last_grant is still updated, so switching back to RR stays fair.
  - Exactly one FIFO is popped per load.
- Latency:
  - A word pushed at edge k is visible in the FIFO after k.
  - It can load into the output register at edge k+1, so out_val is high in the cycle after k+1. Minimum accept-to-out_val is 2 cycles.
  - Sustained throughput is 1 word/cycle total when out_rdy=1.
- Ordering: per-channel FIFO order is preserved. No ordering guarantee across channels beyond the arbitration policy.
- Full/simultaneous cases:
  - On a full FIFO with a same-cycle pop, the push is refused (in_rdy=0 that cycle). The freed slot is visible next cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are determined by the MSB compare.
- Mode or ch_en change mid-stream: takes effect on the next arbitration. Data already in the output register is unaffected.
- Reset mid-operation: all buffered data is discarded and outputs clear immediately on rst_n low.
- Capacity per channel while stalled: FIFO_DEPTH entries, plus 1 in the output register.

Test Plan:
- Single channel: ch1 pushes A0..A3 back-to-back, out_rdy=1, ch_en=3'b111 -> out_val rises 2 cycles after the A0 accept; A0..A3 appear in consecutive cycles with out_ch=1.
- Round-robin: all 3 channels continuously valid, mode_fixed=0, out_rdy=1 -> out_ch sequence 0,1,2,0,1,2,... one word per cycle, no channel skipped.
- Fixed priority: all valid, mode_fixed=1 -> only out_ch=0 while ch0 keeps data. in_rdy[1] and in_rdy[2] drop after 4 accepts each, and their data stays in the FIFOs.
- Backpressure: out_rdy=0, ch0 offers 6 words -> exactly 5 accepted (4 FIFO + 1 output reg), in_rdy[0]=0 afterwards, out_data holds word 0 stable. Raising out_rdy drains words 0..4 in order.
- Masking: ch_en=3'b101, ch1 sends 5 words -> no out_ch=1 output, in_rdy[1]=0 after 4 accepts, busy=1. Setting ch_en=3'b111 releases those 4 words, then the 5th, in order.
- Reset mid-burst: assert rst_n=0 with 3 words buffered and out_val=1 -> out_val/out_data/busy go to 0 without waiting for clk. After release, in_rdy=3'b111 and no stale words are output.

Source files
------------

// File: rtl/psum_gb_rr_merger.sv
// PSUM return-path merger: NUM_CH val/rdy streams, each buffered in its own FIFO,
// arbitrated (round-robin or fixed priority, per-channel maskable) onto a single
// registered GB write port tagged with the source channel.
module psum_gb_rr_merger #(
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned DATA_W     = 368,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CH_W       = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        in_val,
   output logic [NUM_CH-1:0]        in_rdy,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic                     mode_fixed,
   input  logic [NUM_CH-1:0]        ch_en,
   output logic                     out_val,
   input  logic                     out_rdy,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     busy
);

   localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;

   logic [PTR_W-1:0]  wr_ptr [NUM_CH];
   logic [PTR_W-1:0]  rd_ptr [NUM_CH];
   logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];

   logic [NUM_CH-1:0] empty, full, push, pop, elig;
   logic [CH_W-1:0]   grant_idx, last_grant;
   logic [DATA_W-1:0] head_data;
   logic              any_elig, out_adv, load;

   // FIFO status from pointer compare; ready uses pre-pop occupancy, no bypass.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         empty[i] = (wr_ptr[i] == rd_ptr[i]);
         full[i]  = (wr_ptr[i][ADDR_W] != rd_ptr[i][ADDR_W]) &&
                    (wr_ptr[i][ADDR_W-1:0] == rd_ptr[i][ADDR_W-1:0]);
      end
      in_rdy   = ~full;
      push     = in_val & ~full;
      elig     = ~empty & ch_en;
      any_elig = |elig;
      out_adv  = ~out_val | out_rdy;
      load     = out_adv & any_elig;
      busy     = (|(~empty)) | out_val;
   end

   // Grant selection: fixed = lowest eligible index; RR = first eligible after last_grant.
   always_comb begin
      logic            hi_found;
      logic [CH_W-1:0] hi_idx, lo_idx, fix_idx;
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      fix_idx  = '0;
      // Descending scan so the last hit is the lowest qualifying index.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (elig[i]) begin
            fix_idx = CH_W'(i);
            if (CH_W'(i) > last_grant) begin
               hi_found = 1'b1;
               hi_idx   = CH_W'(i);
            end else begin
               lo_idx = CH_W'(i);
            end
         end
      end
      if (mode_fixed) begin
         grant_idx = fix_idx;
      end else begin
         grant_idx = hi_found ? hi_idx : lo_idx;
      end
   end

   // Pop decode and head-of-FIFO mux for the granted channel.
   always_comb begin
      pop       = '0;
      head_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_idx == CH_W'(i)) begin
            pop[i]    = load;
            head_data = mem[i][rd_ptr[i][ADDR_W-1:0]];
         end
      end
   end

   // FIFO pointers; reset discards all buffered words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
         end
      end
   end

   // FIFO storage; contents are don't-care while empty so no reset is needed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) mem[i][wr_ptr[i][ADDR_W-1:0]] <= in_data[i*DATA_W +: DATA_W];
      end
   end

   // Output register and RR pointer; last_grant moves only on an actual load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_val    <= 1'b0;
         out_data   <= '0;
         out_ch     <= '0;
         last_grant <= CH_W'(NUM_CH - 1);
      end else begin
         if (out_adv) out_val <= any_elig;
         if (load) begin
            out_data   <= head_data;
            out_ch     <= grant_idx;
            last_grant <= grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_psum_gb_rr_merger.sv
// Directed bench for psum_gb_rr_merger with default parameters.
module tb_psum_gb_rr_merger;

   localparam int unsigned NCH = 3;
   localparam int unsigned DW  = 368;
   localparam int unsigned CW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    in_val;
   logic [NCH-1:0]    in_rdy;
   logic [NCH*DW-1:0] in_data;
   logic              mode_fixed;
   logic [NCH-1:0]    ch_en;
   logic              out_val;
   logic              out_rdy;
   logic [DW-1:0]     out_data;
   logic [CW-1:0]     out_ch;
   logic              busy;

   int tests = 0;
   int fails = 0;

   psum_gb_rr_merger #(
      .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(4), .CH_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
      .mode_fixed(mode_fixed), .ch_en(ch_en), .out_val(out_val), .out_rdy(out_rdy),
      .out_data(out_data), .out_ch(out_ch), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] word(input int ch, input int n);
      logic [DW-1:0] w;
      w          = '0;
      w[15:0]    = {4'hA, 4'(ch), 8'(n)};
      w[DW-1 -: 16] = ~{4'hA, 4'(ch), 8'(n)};
      return w;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [DW-1:0] d);
      in_data[ch*DW +: DW] = d;
   endtask

   task automatic do_reset();
      in_val = '0;
      rst_n  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int acc;
      bit seen1;
      int exp_ch [9];
      rst_n      = 1'b0;
      in_val     = '0;
      in_data    = '0;
      mode_fixed = 1'b0;
      ch_en      = 3'b111;
      out_rdy    = 1'b1;
      do_reset();

      // Reset state
      chk("rst_out_val", out_val, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_rdy", in_rdy, 3'b111);

      // Single channel: ch1 A0..A3, out_val 2 cycles after first accept
      in_val = 3'b010;
      set_data(1, word(1, 0));
      tick();
      chk("single_latency", out_val, 0);
      for (int n = 1; n <= 4; n++) begin
         if (n < 4) set_data(1, word(1, n));
         else in_val = '0;
         tick();
         chk($sformatf("single_val%0d", n - 1), out_val, 1);
         chk($sformatf("single_data%0d", n - 1), out_data, word(1, n - 1));
         chk($sformatf("single_ch%0d", n - 1), out_ch, 1);
      end
      tick();
      chk("single_drained_val", out_val, 0);
      chk("single_drained_busy", busy, 0);

      // Round-robin with all channels streaming
      do_reset();
      for (int i = 0; i < 3; i++) set_data(i, word(i, 8'h20));
      in_val = 3'b111;
      tick();
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("rr_val%0d", k), out_val, 1);
         chk($sformatf("rr_ch%0d", k), out_ch, k % 3);
         chk($sformatf("rr_data%0d", k), out_data, word(k % 3, 8'h20));
      end

      // Fixed priority: ch0 monopolises, ch1/ch2 fill to 4 and stall
      do_reset();
      mode_fixed = 1'b1;
      for (int i = 0; i < 3; i++) set_data(i, word(i, 8'h30));
      in_val = 3'b111;
      tick();
      for (int k = 2; k <= 6; k++) begin
         tick();
         chk($sformatf("fix_ch0_e%0d", k), out_ch, 0);
         if (k == 4) chk("fix_in_rdy_e4", in_rdy, 3'b001);
      end
      chk("fix_in_rdy_e6", in_rdy, 3'b001);
      in_val = '0;
      exp_ch = '{0, 1, 1, 1, 1, 2, 2, 2, 2};
      for (int k = 0; k < 9; k++) begin
         tick();
         chk($sformatf("fix_drain_ch%0d", k), out_ch, exp_ch[k]);
         chk($sformatf("fix_drain_data%0d", k), out_data, word(exp_ch[k], 8'h30));
      end
      tick();
      chk("fix_drain_done", out_val, 0);
      mode_fixed = 1'b0;

      // Backpressure: 6 offered, 5 accepted, word 0 held
      do_reset();
      out_rdy = 1'b0;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         in_val[0] = (acc < 6);
         set_data(0, word(0, acc));
         if (in_val[0] && in_rdy[0]) acc++;
         tick();
      end
      chk("bp_accepted", acc, 5);
      chk("bp_in_rdy", in_rdy[0], 0);
      chk("bp_hold_val", out_val, 1);
      chk("bp_hold_data", out_data, word(0, 0));
      in_val  = '0;
      out_rdy = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         chk($sformatf("bp_drain%0d", n), out_data, word(0, n));
      end
      tick();
      chk("bp_drain_done", out_val, 0);

      // Masking: ch1 disabled, 4 buffered then released in order
      do_reset();
      ch_en = 3'b101;
      acc   = 0;
      seen1 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         in_val[1] = (acc < 5);
         set_data(1, word(1, 8'h40 + acc));
         if (in_val[1] && in_rdy[1]) acc++;
         tick();
         if (out_val) seen1 = 1'b1;
      end
      chk("mask_no_output", seen1, 0);
      chk("mask_accepted", acc, 4);
      chk("mask_in_rdy", in_rdy[1], 0);
      chk("mask_busy", busy, 1);
      ch_en = 3'b111;
      for (int n = 0; n < 5; n++) begin
         in_val[1] = (acc < 5);
         set_data(1, word(1, 8'h40 + acc));
         if (in_val[1] && in_rdy[1]) acc++;
         tick();
         chk($sformatf("mask_rel_val%0d", n), out_val, 1);
         chk($sformatf("mask_rel_data%0d", n), out_data, word(1, 8'h40 + n));
      end
      in_val = '0;

      // Reset mid-burst: async clear, no stale data afterwards
      do_reset();
      out_rdy = 1'b0;
      in_val  = 3'b100;
      for (int n = 0; n < 4; n++) begin
         set_data(2, word(2, 8'h50 + n));
         tick();
      end
      in_val = '0;
      chk("mrst_pre_val", out_val, 1);
      chk("mrst_pre_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_async_val", out_val, 0);
      chk("mrst_async_data", out_data, 0);
      chk("mrst_async_busy", busy, 0);
      tick();
      rst_n   = 1'b1;
      out_rdy = 1'b1;
      chk("mrst_in_rdy", in_rdy, 3'b111);
      seen1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (out_val) seen1 = 1'b1;
      end
      chk("mrst_no_stale", seen1, 0);
      chk("mrst_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
